// File: rtl/plt_reset_pkg.sv
// Shared definitions for the platform reset sequencer: state encoding and
// elaboration-time sizing helpers.
package plt_reset_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWRON_WAIT = 3'd1,
        ST_CPU_REL    = 3'd2,
        ST_RUN        = 3'd3,
        ST_IO_ASSERT  = 3'd4,
        ST_HOLD       = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/plt_reset_ctrl_us_timer.sv
// Microsecond-tick state timer. Counts t1us ticks since the last clear and
// flags the tick that completes a duration of 'target' microseconds.
module us_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] target,
    output logic         done
);

    logic [W-1:0] cnt;

    // Count ticks since the last clear, parking at target so long waits never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick && (cnt != target)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = tick && (cnt == (target - 1'b1));

endmodule

// File: rtl/plt_reset_ctrl.sv
// Platform reset sequencer: turns the system-reset request and power status
// into ordered CPU / IO resets (IO asserts first, CPU releases first).
module plt_reset_ctrl
    import plt_reset_pkg::*;
#(
    parameter int NUM_IO        = 1,
    parameter int PWRON_DLY_US  = 100,
    parameter int CPU_TO_IO_US  = 10,
    parameter int MIN_HOLD_US   = 1000,
    parameter int REQ_FILTER_US = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t1us,
    input  logic              st_steady_pwrok,
    input  logic              rt_critical_fail_store,
    input  logic              sys_reset_req,
    input  logic              rst_pcie_cpu_n,
    output logic              rst_cpu_n,
    output logic [NUM_IO-1:0] rst_io_n,
    output logic              plt_rst_active,
    output logic [7:0]        rst_event_cnt,
    output logic [2:0]        state_dbg
);

    localparam int TMR_W = clogb2(max3(PWRON_DLY_US, CPU_TO_IO_US, MIN_HOLD_US)) + 1;
    localparam int FLT_W = clogb2(REQ_FILTER_US) + 1;

    localparam logic [TMR_W-1:0] T_PWRON = TMR_W'(PWRON_DLY_US);
    localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(CPU_TO_IO_US);
    localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(MIN_HOLD_US);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(REQ_FILTER_US);

    state_t             state;
    state_t             next_state;
    logic               pwr_bad;
    logic               req_accept;
    logic               tmr_clr;
    logic               tmr_done;
    logic               hold_met;
    logic [TMR_W-1:0]   tmr_target;
    logic [FLT_W-1:0]   filt;
    logic               cpu_d;
    logic [NUM_IO-1:0]  io_d;
    logic               active_d;

    assign pwr_bad    = !st_steady_pwrok || rt_critical_fail_store;
    assign req_accept = (state == ST_RUN) && sys_reset_req && (filt == FLT_MAX);
    assign tmr_clr    = (next_state != state);
    assign state_dbg  = state;

    // Duration of the current state; untimed states leave the timer parked at zero.
    always_comb begin
        tmr_target = '0;
        case (state)
            ST_PWRON_WAIT: tmr_target = T_PWRON;
            ST_CPU_REL:    tmr_target = T_GAP;
            ST_IO_ASSERT:  tmr_target = T_GAP;
            ST_HOLD:       tmr_target = T_HOLD;
            default:       tmr_target = '0;
        endcase
    end

    us_timer #(
        .W(TMR_W)
    ) u_state_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .tick   (t1us),
        .target (tmr_target),
        .done   (tmr_done)
    );

    // Remember that the minimum hold has elapsed while the request keeps HOLD busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_met <= 1'b0;
        end else if (tmr_clr) begin
            hold_met <= 1'b0;
        end else if ((state == ST_HOLD) && tmr_done) begin
            hold_met <= 1'b1;
        end
    end

    // Request deglitch: ticks of continuous request while running, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
        end else if ((state != ST_RUN) || !sys_reset_req) begin
            filt <= '0;
        end else if (t1us && (filt != FLT_MAX)) begin
            filt <= filt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; losing power overrides every other transition.
    always_comb begin
        next_state = state;
        if (pwr_bad) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:        next_state = ST_PWRON_WAIT;
                ST_PWRON_WAIT: if (tmr_done) next_state = ST_CPU_REL;
                ST_CPU_REL:    if (tmr_done) next_state = ST_RUN;
                ST_RUN:        if (req_accept) next_state = ST_IO_ASSERT;
                ST_IO_ASSERT:  if (tmr_done) next_state = ST_HOLD;
                ST_HOLD:       if ((tmr_done || hold_met) && !sys_reset_req) next_state = ST_CPU_REL;
                default:       next_state = ST_OFF;
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        cpu_d    = 1'b0;
        io_d     = '0;
        active_d = 1'b1;
        case (next_state)
            ST_CPU_REL, ST_IO_ASSERT: cpu_d = 1'b1;
            ST_RUN: begin
                cpu_d    = 1'b1;
                io_d     = {NUM_IO{rst_pcie_cpu_n}};
                active_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered reset outputs and the saturating accepted-request counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cpu_n      <= 1'b0;
            rst_io_n       <= '0;
            plt_rst_active <= 1'b1;
            rst_event_cnt  <= 8'd0;
        end else begin
            rst_cpu_n      <= cpu_d;
            rst_io_n       <= io_d;
            plt_rst_active <= active_d;
            if ((state == ST_RUN) && (next_state == ST_IO_ASSERT) && (rst_event_cnt != 8'hFF)) begin
                rst_event_cnt <= rst_event_cnt + 8'd1;
            end
        end
    end

endmodule
